// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared CPU definitions: fetch FSM states, ALU control codes and the default reset PC.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StReq     = 3'd1,
    StWaitRsp = 3'd2,
    StHold    = 3'd3,
    StErr     = 3'd4
  } fetch_state_e;

  localparam logic [10:0] BRANCH      = 11'd31;
  localparam logic [10:0] BRANCH_LINK = 11'd32;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  // A retiring instruction writes R14 only when its control code is the link code.
  function automatic logic is_link(input logic [10:0] code, input logic [10:0] bl_code);
    return code == bl_code;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller signal bundle: imem handshake, decode handshake, next-PC and R14 write.
interface pc_fetch_ctrl_if;
  logic        halt;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] program_counter;
  logic [31:0] program_counter_next;
  logic [10:0] alu_ctl_code;
  logic [31:0] next_r14;
  logic        r14_we;
  logic [31:0] r14_wdata;
  logic [31:0] retired_count;
  logic        fetch_err;

  modport master (
    input  halt, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           program_counter_next, alu_ctl_code, next_r14,
    output imem_req_valid, imem_req_addr, instr_valid, instr, program_counter,
           r14_we, r14_wdata, retired_count, fetch_err
  );

  modport slave (
    output halt, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
           program_counter_next, alu_ctl_code, next_r14,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, program_counter,
           r14_we, r14_wdata, retired_count, fetch_err
  );
endinterface

// File: rtl/pc_fetch_ctrl_timeout_ctr.sv
// Fetch response watchdog: counts response-less wait cycles and flags the last one.
module fetch_timeout_ctr #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose increment would reach TimeoutCycles.
  assign expire_o = tick_i && (cnt_q == LastCnt);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and single-outstanding instruction fetch controller.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter logic [10:0] BL_CODE        = BRANCH_LINK,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic            clk,
  input logic            reset_n,
  pc_fetch_ctrl_if.master bus
);

  fetch_state_e state_q;
  logic         req_valid_q;
  logic         instr_valid_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic         r14_we_q;
  logic [31:0]  r14_wdata_q;
  logic [31:0]  retired_q;
  logic         fetch_err_q;
  logic         timeout_expire;

  logic req_fire;
  logic wait_idle;
  assign req_fire  = (state_q == StReq) && bus.imem_req_ready;
  assign wait_idle = (state_q == StWaitRsp) && !bus.imem_rsp_valid;

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clear_i (req_fire),
    .tick_i  (wait_idle),
    .expire_o(timeout_expire)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, wait_idle};
  assign timeout_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= 32'd0;
      pc_q          <= RESET_PC;
      r14_we_q      <= 1'b0;
      r14_wdata_q   <= 32'd0;
      retired_q     <= 32'd0;
      fetch_err_q   <= 1'b0;
    end else begin
      r14_we_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!bus.halt) begin
            state_q     <= StReq;
            req_valid_q <= 1'b1;
          end
        end
        StReq: begin
          if (req_fire) begin
            state_q     <= StWaitRsp;
            req_valid_q <= 1'b0;
          end
        end
        StWaitRsp: begin
          // A response in the expiry cycle still wins over the timeout.
          if (bus.imem_rsp_valid) begin
            instr_q       <= bus.imem_rsp_data;
            instr_valid_q <= 1'b1;
            state_q       <= StHold;
          end else if (timeout_expire) begin
            fetch_err_q <= 1'b1;
            state_q     <= StErr;
          end
        end
        StHold: begin
          if (bus.instr_ready) begin
            pc_q          <= bus.program_counter_next;
            retired_q     <= retired_q + 32'd1;
            instr_valid_q <= 1'b0;
            if (is_link(bus.alu_ctl_code, BL_CODE)) begin
              r14_we_q    <= 1'b1;
              r14_wdata_q <= bus.next_r14;
            end
            if (!bus.halt) begin
              state_q     <= StReq;
              req_valid_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StErr: begin
          req_valid_q   <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: begin
          state_q       <= StIdle;
          req_valid_q   <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req_valid  = req_valid_q;
  assign bus.imem_req_addr   = pc_q;
  assign bus.instr_valid     = instr_valid_q;
  assign bus.instr           = instr_q;
  assign bus.program_counter = pc_q;
  assign bus.r14_we          = r14_we_q;
  assign bus.r14_wdata       = r14_wdata_q;
  assign bus.retired_count   = retired_q;
  assign bus.fetch_err       = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vectors plus a randomized transaction model.
module tb_pc_fetch_ctrl;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if ifc ();

  pc_fetch_ctrl #(
    .RESET_PC      (32'd0),
    .BL_CODE       (11'd32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  int total = 0;
  int bad = 0;
  int edge_no = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [31:0] hs_addr[$];
  int          hs_edge[$];

  typedef struct {
    logic [31:0] pc;
    logic [10:0] code;
    logic [31:0] nxt;
    logic [31:0] r14;
    logic        exp_we;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic idle_inputs();
    ifc.imem_req_ready       = 1'b0;
    ifc.imem_rsp_valid       = 1'b0;
    ifc.imem_rsp_data        = 32'd0;
    ifc.instr_ready          = 1'b0;
    ifc.program_counter_next = 32'd0;
    ifc.alu_ctl_code         = 11'd0;
    ifc.next_r14             = 32'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, ifc.imem_req_valid, 0);
    check({tag, "_instr_valid"}, ifc.instr_valid, 0);
    check({tag, "_instr"}, ifc.instr, 0);
    check({tag, "_pc"}, ifc.program_counter, 0);
    check({tag, "_r14_we"}, ifc.r14_we, 0);
    check({tag, "_r14_wdata"}, ifc.r14_wdata, 0);
    check({tag, "_retired"}, ifc.retired_count, 0);
    check({tag, "_fetch_err"}, ifc.fetch_err, 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    ifc.halt = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    check_reset_vals("rst");
    reset_n = 1'b1;
    exp_pc  = 32'd0;
    exp_ret = 32'd0;
    edge_no = 0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!ifc.imem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check(name, ifc.imem_req_valid, 1);
  endtask

  // One full fetch/retire with zero-wait memory; leaves the next request pending.
  task automatic fetch_one(input logic [31:0] nxt, input logic [10:0] code, input logic [31:0] r14,
                           output logic [31:0] addr, output logic we, output logic [31:0] wd);
    idle_inputs();
    wait_req("fo_req_seen");
    addr = ifc.imem_req_addr;
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = mem_word(addr);
    tick();
    ifc.imem_rsp_valid = 1'b0;
    check("fo_hold_valid", ifc.instr_valid, 1);
    check("fo_hold_instr", ifc.instr, mem_word(addr));
    ifc.instr_ready          = 1'b1;
    ifc.program_counter_next = nxt;
    ifc.alu_ctl_code         = code;
    ifc.next_r14             = r14;
    tick();
    ifc.instr_ready  = 1'b0;
    we               = ifc.r14_we;
    wd               = ifc.r14_wdata;
    ifc.next_r14     = ~r14;
    ifc.alu_ctl_code = 11'd0;
    tick();
    check("fo_r14_pulse_end", ifc.r14_we, 0);
  endtask

  // Cycle-driven environment checked against a transaction-level model of fetch/retire.
  task automatic run_env(input int cycles, input int rdy_pct, input bit pc_inc);
    logic p_req_v, p_req_rdy, p_rsp_v, p_iv, p_irdy;
    logic [31:0] p_addr, p_next, p_r14, faddr;
    logic [10:0] p_code;
    bit pending = 0;
    int dly = 0;
    faddr     = 32'd0;
    p_req_v   = ifc.imem_req_valid;
    p_addr    = ifc.imem_req_addr;
    p_iv      = ifc.instr_valid;
    p_req_rdy = ifc.imem_req_ready;
    p_rsp_v   = ifc.imem_rsp_valid;
    p_irdy    = ifc.instr_ready;
    p_next    = ifc.program_counter_next;
    p_code    = ifc.alu_ctl_code;
    p_r14     = ifc.next_r14;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (p_req_v && p_req_rdy) begin
        check("env_req_addr", p_addr, exp_pc);
        check("env_one_outstanding", {31'd0, p_iv}, 0);
        hs_addr.push_back(p_addr);
        hs_edge.push_back(edge_no);
        pending = 1;
        faddr   = p_addr;
        dly     = (rdy_pct >= 100) ? 0 : int'($urandom_range(0, 3));
      end
      if (p_rsp_v) begin
        check("env_capture_valid", ifc.instr_valid, 1);
        check("env_capture_data", ifc.instr, mem_word(faddr));
      end
      if (p_iv && p_irdy) begin
        exp_ret = exp_ret + 32'd1;
        exp_pc  = p_next;
        if (p_code == BRANCH_LINK) begin
          check("env_r14_we", ifc.r14_we, 1);
          check("env_r14_wdata", ifc.r14_wdata, p_r14);
        end else begin
          check("env_r14_quiet", ifc.r14_we, 0);
        end
      end else begin
        check("env_r14_idle", ifc.r14_we, 0);
      end
      check("env_pc", ifc.program_counter, exp_pc);
      check("env_retired", ifc.retired_count, exp_ret);
      ifc.imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      ifc.imem_rsp_valid = 1'b0;
      ifc.imem_rsp_data  = $urandom;
      if (pending) begin
        if (dly == 0) begin
          ifc.imem_rsp_valid = 1'b1;
          ifc.imem_rsp_data  = mem_word(faddr);
          pending = 0;
        end else begin
          dly--;
        end
      end
      ifc.instr_ready = ($urandom_range(0, 99) < rdy_pct);
      ifc.program_counter_next = pc_inc ? ifc.program_counter + 32'd1 : $urandom;
      case ($urandom_range(0, 3))
        0:       ifc.alu_ctl_code = BRANCH_LINK;
        1:       ifc.alu_ctl_code = BRANCH;
        default: ifc.alu_ctl_code = 11'($urandom);
      endcase
      ifc.next_r14 = $urandom;
      p_req_v   = ifc.imem_req_valid;
      p_addr    = ifc.imem_req_addr;
      p_iv      = ifc.instr_valid;
      p_req_rdy = ifc.imem_req_ready;
      p_rsp_v   = ifc.imem_rsp_valid;
      p_irdy    = ifc.instr_ready;
      p_next    = ifc.program_counter_next;
      p_code    = ifc.alu_ctl_code;
      p_r14     = ifc.next_r14;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    logic [31:0] addr, wd, a0;
    logic we;

    vecs[0] = '{pc: 32'd675, code: BRANCH_LINK, nxt: 32'd1275, r14: 32'd676, exp_we: 1'b1};
    vecs[1] = '{pc: 32'd234, code: BRANCH, nxt: 32'd734, r14: 32'd235, exp_we: 1'b0};
    vecs[2] = '{pc: 32'd1275, code: BRANCH_LINK, nxt: 32'd0, r14: 32'd1276, exp_we: 1'b1};
    vecs[3] = '{pc: 32'd0, code: 11'd0, nxt: 32'hFFFF_FFFF, r14: 32'd1, exp_we: 1'b0};
    vecs[4] = '{pc: 32'hFFFF_FFFF, code: BRANCH_LINK, nxt: 32'd5, r14: 32'h0000_0ABC,
                exp_we: 1'b1};

    // Reset then zero-wait sequential fetch.
    do_reset();
    ifc.imem_req_ready = 1'b1;
    ifc.instr_ready    = 1'b1;
    ifc.program_counter_next = 32'd1;
    run_env(13, 100, 1'b1);
    check("seq_hs_count", hs_addr.size(), 4);
    for (int k = 0; k < 4 && k < hs_addr.size(); k++) begin
      check("seq_addr", hs_addr[k], k);
      check("seq_edge", hs_edge[k], 2 + 3 * k);
    end
    check("seq_retired", ifc.retired_count, 4);

    // Branch / branch-link vectors.
    for (int i = 0; i < 5; i++) begin
      fetch_one(vecs[i].pc, 11'd0, 32'd0, addr, we, wd);
      fetch_one(vecs[i].nxt, vecs[i].code, vecs[i].r14, addr, we, wd);
      check("vec_addr", addr, vecs[i].pc);
      check("vec_r14_we", we, vecs[i].exp_we);
      if (vecs[i].exp_we) check("vec_r14_wdata", wd, vecs[i].r14);
      check("vec_pc", ifc.program_counter, vecs[i].nxt);
      check("vec_next_req_valid", ifc.imem_req_valid, 1);
      check("vec_next_req_addr", ifc.imem_req_addr, vecs[i].nxt);
    end

    // Backpressure on request and on decode.
    idle_inputs();
    a0 = ifc.imem_req_addr;
    check("bp_start_addr", a0, 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_req_valid", ifc.imem_req_valid, 1);
      check("bp_req_addr", ifc.imem_req_addr, 5);
    end
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = mem_word(32'd5);
    tick();
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = 32'h1111_1111;
    ifc.program_counter_next = 32'd77;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_instr_valid", ifc.instr_valid, 1);
      check("bp_instr", ifc.instr, mem_word(32'd5));
      check("bp_pc", ifc.program_counter, 5);
    end
    ifc.instr_ready = 1'b1;
    tick();
    ifc.instr_ready = 1'b0;
    check("bp_pc_after", ifc.program_counter, 77);

    // Reset while waiting for a response; stale response afterwards.
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    ifc.halt = 1'b1;
    tick();
    reset_n = 1'b1;
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    ifc.imem_rsp_valid = 1'b0;
    check("stale_instr_valid", ifc.instr_valid, 0);
    check("stale_instr", ifc.instr, 0);
    tick();
    tick();
    check("halt_idle_no_req", ifc.imem_req_valid, 0);
    ifc.halt = 1'b0;
    fetch_one(32'd10, 11'd0, 32'd0, addr, we, wd);
    check("post_rst_addr", addr, 0);

    // Halt raised during the wait: instruction completes, then fetch stops.
    wait_req("halt_req_seen");
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    ifc.halt = 1'b1;
    tick();
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = mem_word(32'd10);
    tick();
    ifc.imem_rsp_valid = 1'b0;
    check("halt_capture", ifc.instr_valid, 1);
    ifc.instr_ready = 1'b1;
    ifc.program_counter_next = 32'd20;
    tick();
    ifc.instr_ready = 1'b0;
    check("halt_retired", ifc.retired_count, 2);
    ifc.imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("halt_no_req", ifc.imem_req_valid, 0);
    end
    check("halt_pc", ifc.program_counter, 20);
    ifc.imem_req_ready = 1'b0;
    ifc.halt = 1'b0;
    tick();
    tick();
    check("halt_resume_req", ifc.imem_req_valid, 1);
    check("halt_resume_addr", ifc.imem_req_addr, 20);

`ifdef FETCH_TIMEOUT_EN
    // No response: error after 16 wait cycles, then absorbing.
    do_reset();
    wait_req("to_req_seen");
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_err_before", ifc.fetch_err, 0);
    tick();
    check("to_err_set", ifc.fetch_err, 1);
    ifc.imem_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("to_no_req", ifc.imem_req_valid, 0);
      check("to_no_instr", ifc.instr_valid, 0);
    end
    check("to_err_sticky", ifc.fetch_err, 1);
    // Response on exactly the 16th wait cycle wins.
    do_reset();
    wait_req("to2_req_seen");
    ifc.imem_req_ready = 1'b1;
    tick();
    ifc.imem_req_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    ifc.imem_rsp_valid = 1'b1;
    ifc.imem_rsp_data  = 32'h0BAD_F00D;
    tick();
    ifc.imem_rsp_valid = 1'b0;
    check("to2_capture", ifc.instr_valid, 1);
    check("to2_instr", ifc.instr, 32'h0BAD_F00D);
    check("to2_no_err", ifc.fetch_err, 0);
`endif

    // Randomized traffic against the model.
    do_reset();
    hs_addr.delete();
    hs_edge.delete();
    run_env(3000, 70, 1'b0);
    check("rand_progress", (hs_addr.size() > 100) ? 32'd1 : 32'd0, 1);
    check("rand_no_err", ifc.fetch_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
